// File: rtl/i2c_temp_poll_ctrl.sv
// I2C master that periodically reads a 16-bit temperature register from a bus sensor.
// Define TEMP_ALERT_EN to add threshold inputs and a registered over/under-range alert output.
module i2c_temp_poll_ctrl #(
  parameter int unsigned CLK_DIV     = 25,
  parameter logic [6:0]  SLAVE_ADR   = 7'h10,
  parameter logic [7:0]  TEMP_PTR    = 8'h00,
  parameter int unsigned POLL_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic [15:0] temperature,
  output logic        temp_valid,
  output logic        busy,
`ifdef TEMP_ALERT_EN
  input  logic [15:0] thr_high,
  input  logic [15:0] thr_low,
  output logic        alert,
`endif
  output logic        ack_error
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW = $clog2(POLL_PERIOD + 1);
  localparam logic [QW-1:0] QMax  = QW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TLoad = TW'(POLL_PERIOD - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddrW, StAck1, StPtr, StAck2, StRstart, StAddrR,
    StAck3, StRdMsb, StMack, StRdLsb, StMnack, StStop, StWait
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   qcnt_q;
  logic [1:0]      phase_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shreg_q, msb_q;
  logic [TW-1:0]   timer_q;
  logic            ack_bit_q, err_q;
  logic            sda_s1_q, sda_s2_q;
  logic            scl_oe_q, sda_oe_q, scl_oe_d, sda_oe_d;
  logic [15:0]     temp_q;
  logic            temp_valid_q, ack_error_q;
  logic            in_bit, bit_end, sample_pt, scl_lo;
  logic            tx_state, rx_state, ack_state;

  assign in_bit    = (state_q != StIdle) && (state_q != StWait);
  assign bit_end   = in_bit && (phase_q == 2'd3) && (qcnt_q == QMax);
  assign sample_pt = in_bit && (phase_q == 2'd2) && (qcnt_q == QMax);
  assign scl_lo    = ~phase_q[1];
  assign tx_state  = state_q inside {StAddrW, StPtr, StAddrR};
  assign rx_state  = state_q inside {StRdMsb, StRdLsb};
  assign ack_state = state_q inside {StAck1, StAck2, StAck3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable && timer_q == '0) state_d = StStart;
      StStart:  if (bit_end) state_d = StAddrW;
      StAddrW:  if (bit_end && bitcnt_q == 3'd7) state_d = StAck1;
      StAck1:   if (bit_end) state_d = ack_bit_q ? StStop : StPtr;
      StPtr:    if (bit_end && bitcnt_q == 3'd7) state_d = StAck2;
      StAck2:   if (bit_end) state_d = ack_bit_q ? StStop : StRstart;
      StRstart: if (bit_end) state_d = StAddrR;
      StAddrR:  if (bit_end && bitcnt_q == 3'd7) state_d = StAck3;
      StAck3:   if (bit_end) state_d = ack_bit_q ? StStop : StRdMsb;
      StRdMsb:  if (bit_end && bitcnt_q == 3'd7) state_d = StMack;
      StMack:   if (bit_end) state_d = StRdLsb;
      StRdLsb:  if (bit_end && bitcnt_q == 3'd7) state_d = StMnack;
      StMnack:  if (bit_end) state_d = StStop;
      StStop:   if (bit_end) state_d = StWait;
      // Going straight to START keeps STOP-to-START at exactly POLL_PERIOD cycles.
      StWait:   if (timer_q == '0) state_d = enable ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    unique case (state_q)
      StStart: begin
        scl_oe_d = (phase_q == 2'd3);
        sda_oe_d = (phase_q != 2'd0);
      end
      StAddrW, StPtr, StAddrR: begin
        scl_oe_d = scl_lo;
        sda_oe_d = ~shreg_q[7];
      end
      StAck1, StAck2, StAck3, StRdMsb, StRdLsb, StMnack: scl_oe_d = scl_lo;
      StMack: begin
        scl_oe_d = scl_lo;
        sda_oe_d = 1'b1;
      end
      StRstart: begin
        scl_oe_d = scl_lo;
        sda_oe_d = (phase_q == 2'd3);
      end
      StStop: begin
        scl_oe_d = scl_lo;
        sda_oe_d = (phase_q != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt_q       <= '0;
      phase_q      <= 2'd0;
      bitcnt_q     <= 3'd0;
      shreg_q      <= 8'h00;
      msb_q        <= 8'h00;
      timer_q      <= '0;
      ack_bit_q    <= 1'b0;
      err_q        <= 1'b0;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      temp_q       <= 16'h0000;
      temp_valid_q <= 1'b0;
      ack_error_q  <= 1'b0;
`ifdef TEMP_ALERT_EN
      alert        <= 1'b0;
`endif
    end else begin
      sda_s1_q     <= sda_i;
      sda_s2_q     <= sda_s1_q;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
      temp_valid_q <= 1'b0;
      ack_error_q  <= 1'b0;
      if (!in_bit) begin
        qcnt_q  <= '0;
        phase_q <= 2'd0;
      end else if (qcnt_q == QMax) begin
        qcnt_q  <= '0;
        phase_q <= phase_q + 2'd1;
      end else begin
        qcnt_q <= qcnt_q + QW'(1);
      end
      if (sample_pt) begin
        if (ack_state) ack_bit_q <= sda_s2_q;
        if (rx_state)  shreg_q   <= {shreg_q[6:0], sda_s2_q};
      end
      if (bit_end) begin
        if (tx_state) shreg_q <= {shreg_q[6:0], 1'b0};
        if (tx_state || rx_state) bitcnt_q <= bitcnt_q + 3'd1;
        if (ack_state && ack_bit_q) begin
          ack_error_q <= 1'b1;
          err_q       <= 1'b1;
        end
        unique case (state_q)
          StStart:  shreg_q <= {SLAVE_ADR, 1'b0};
          StAck1:   shreg_q <= TEMP_PTR;
          StRstart: shreg_q <= {SLAVE_ADR, 1'b1};
          StRdMsb:  if (bitcnt_q == 3'd7) msb_q <= shreg_q;
          StStop: begin
            timer_q <= TLoad;
            if (!err_q) begin
              temp_q       <= {msb_q, shreg_q};
              temp_valid_q <= 1'b1;
`ifdef TEMP_ALERT_EN
              alert <= ($signed({msb_q, shreg_q}) > $signed(thr_high)) ||
                       ($signed({msb_q, shreg_q}) < $signed(thr_low));
`endif
            end
          end
          default: ;
        endcase
      end
      if (state_q == StWait && timer_q != '0) timer_q <= timer_q - TW'(1);
      if (state_d == StStart && state_q != StStart) err_q <= 1'b0;
    end
  end

  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;
  assign temperature = temp_q;
  assign temp_valid  = temp_valid_q;
  assign ack_error   = ack_error_q;
  assign busy        = in_bit;

endmodule

// File: tb/tb_i2c_temp_poll_ctrl.sv
// Directed bench for i2c_temp_poll_ctrl with a cycle-sampled sensor slave model on the bus.
module tb_i2c_temp_poll_ctrl;

  localparam int unsigned ClkDiv     = 4;
  localparam int unsigned PollPeriod = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        scl_oe, sda_oe, sda_i, temp_valid, busy, ack_error;
  logic [15:0] temperature;
`ifdef TEMP_ALERT_EN
  logic [15:0] thr_high = 16'h1900;
  logic [15:0] thr_low  = 16'h0000;
  logic        alert;
`endif

  logic       slv_low = 1'b0;
  logic       scl_line, sda_line;
  logic [6:0]  slv_adr  = 7'h10;
  logic [15:0] slv_temp = 16'h1A40;
  logic [7:0]  slv_ptr  = 8'hFF;

  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slv_low);
  assign sda_i    = sda_line;

  i2c_temp_poll_ctrl #(
    .CLK_DIV    (ClkDiv),
    .SLAVE_ADR  (7'h10),
    .TEMP_PTR   (8'h00),
    .POLL_PERIOD(PollPeriod)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i),
    .temperature(temperature),
    .temp_valid (temp_valid),
    .busy       (busy),
`ifdef TEMP_ALERT_EN
    .thr_high   (thr_high),
    .thr_low    (thr_low),
    .alert      (alert),
`endif
    .ack_error  (ack_error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event monitor, sampled on the falling edge.
  int   tv_cnt = 0, tv_cyc = 0, rise_cnt = 0, rise_cyc = 0, fall_cyc = 0, ae_cnt = 0, ae_cyc = 0;
  logic tv_busy = 1'b0, busy_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (busy && !busy_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (!busy && busy_prev) fall_cyc = cyc;
    if (temp_valid) begin
      tv_cnt++;
      tv_cyc  = cyc;
      tv_busy = busy;
    end
    if (ack_error) begin
      ae_cnt++;
      ae_cyc = cyc;
    end
    busy_prev = busy;
  end

  // Sensor slave: receives address/pointer, returns slv_temp MSB first.
  typedef enum int {SIdle, SAddr, SWr, SRd} smode_e;
  smode_e smode = SIdle;
  initial begin : slave
    logic       scl_p, sda_p, scl_n, sda_n, rw, mnack;
    logic [7:0] sh, rbyte;
    int         rc, bidx;
    scl_p = 1'b1; sda_p = 1'b1; rw = 1'b0; mnack = 1'b0;
    sh = 8'h00; rbyte = 8'h00; rc = 0; bidx = 0;
    forever begin
      @(negedge clk);
      scl_n = scl_line;
      sda_n = sda_line;
      if (rst) begin
        smode = SIdle; slv_low = 1'b0; rc = 0;
      end else if (scl_p && scl_n && sda_p && !sda_n) begin
        smode = SAddr; rc = 0; sh = 8'h00; slv_low = 1'b0;
      end else if (scl_p && scl_n && !sda_p && sda_n) begin
        smode = SIdle; slv_low = 1'b0;
      end else if (smode != SIdle) begin
        if (!scl_p && scl_n) begin
          rc++;
          if (rc <= 8 && smode != SRd) sh = {sh[6:0], sda_n};
          if (rc == 9 && smode == SRd) mnack = sda_n;
        end else if (scl_p && !scl_n) begin
          if (rc == 8) begin
            if (smode == SAddr) begin
              if (sh[7:1] == slv_adr) begin
                slv_low = 1'b1; rw = sh[0];
              end else begin
                smode = SIdle;
              end
            end else if (smode == SWr) begin
              slv_ptr = sh; slv_low = 1'b1;
            end else begin
              slv_low = 1'b0;
            end
          end else if (rc == 9) begin
            rc = 0; slv_low = 1'b0;
            if (smode == SAddr) begin
              smode = rw ? SRd : SWr; bidx = 0;
            end else if (smode == SRd) begin
              if (mnack) smode = SIdle;
              else bidx++;
            end
            if (smode == SRd) begin
              rbyte = (bidx == 0) ? slv_temp[15:8] : slv_temp[7:0];
              slv_low = ~rbyte[7];
            end
          end else if (smode == SRd && rc >= 1 && rc <= 7) begin
            rbyte = (bidx == 0) ? slv_temp[15:8] : slv_temp[7:0];
            slv_low = ~rbyte[7-rc];
          end
        end
      end
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  int n_chk = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_tv(input int target, input int limit);
    for (int i = 0; i < limit && tv_cnt < target; i++) tick();
    check_eq("tv_arrive", tv_cnt, target);
  endtask

  task automatic wait_rise(input int target, input int limit);
    for (int i = 0; i < limit && rise_cnt < target; i++) tick();
    check_eq("start_arrive", rise_cnt, target);
  endtask

  task automatic wait_ae(input int target, input int limit);
    for (int i = 0; i < limit && ae_cnt < target; i++) tick();
    check_eq("nack_arrive", ae_cnt, target);
  endtask

  int tv1, r4, r5;

  initial begin
    repeat (3) tick();
    check_eq("rst_scl_oe", scl_oe, 0);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_temp", temperature, 16'h0000);
    check_eq("rst_temp_valid", temp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack_error", ack_error, 0);
`ifdef TEMP_ALERT_EN
    check_eq("rst_alert", alert, 0);
`endif
    rst = 1'b0;
    tick();
    check_eq("idle_no_enable", busy, 0);
    enable = 1'b1;
    tick();
    check_eq("start_next_cycle", busy, 1);

    // First read: 48 bit-times of 16 cycles each.
    wait_tv(1, 1000);
    check_eq("read1_len", tv_cyc - rise_cyc, 768);
    check_eq("tv_with_busy_low", tv_busy, 0);
    check_eq("read1_temp", temperature, 16'h1A40);
    check_eq("read1_no_nack", ae_cnt, 0);
    check_eq("pointer_sent", slv_ptr, 8'h00);
    tv1 = tv_cyc;
    slv_temp = 16'hFF80;
    repeat (3) tick();
    check_eq("tv_one_pulse", tv_cnt, 1);

    wait_rise(2, 400);
    check_eq("poll_gap", rise_cyc - tv1, PollPeriod);
    wait_tv(2, 1000);
    check_eq("read2_spacing", tv_cyc - tv1, 968);
    check_eq("read2_temp", temperature, 16'hFF80);
    check_eq("read2_no_nack", ae_cnt, 0);

    // Reset in the middle of RD_MSB, at a point where SCL is held low.
    wait_rise(3, 400);
    repeat (480) tick();
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_scl", scl_oe, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_scl_oe", scl_oe, 0);
    check_eq("mid_rst_sda_oe", sda_oe, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_temp", temperature, 16'h0000);
    repeat (3) tick();
    slv_adr  = 7'h11;
    slv_temp = 16'h1A40;
    rst = 1'b0;

    // Address not acknowledged: NACK at the end of ACK1, then STOP and a normal wait.
    wait_rise(4, 20);
    r4 = rise_cyc;
    wait_ae(1, 400);
    check_eq("nack_time", ae_cyc - r4, 160);
    slv_adr = 7'h10;
    wait_rise(5, 600);
    check_eq("nack_stop_done", fall_cyc - r4, 176);
    check_eq("nack_retry_gap", rise_cyc - fall_cyc, PollPeriod);
    check_eq("nack_no_tv", tv_cnt, 2);
    check_eq("nack_temp_kept", temperature, 16'h0000);
    check_eq("nack_one_pulse", ae_cnt, 1);
    r5 = rise_cyc;
    wait_tv(3, 1000);
    check_eq("retry_len", tv_cyc - r5, 768);
    check_eq("retry_temp", temperature, 16'h1A40);
`ifdef TEMP_ALERT_EN
    check_eq("alert_high", alert, 1);
`endif

    // Drop enable during PTR: the transaction still finishes, then polling stops.
    slv_temp = 16'h0C80;
    wait_rise(6, 400);
    repeat (192) tick();
    enable = 1'b0;
    wait_tv(4, 1000);
    check_eq("dis_temp", temperature, 16'h0C80);
    check_eq("dis_tv_busy", tv_busy, 0);
`ifdef TEMP_ALERT_EN
    check_eq("alert_clear", alert, 0);
`endif
    repeat (5 * PollPeriod) tick();
    check_eq("dis_no_start", rise_cnt, 6);
    check_eq("dis_idle", busy, 0);
    check_eq("dis_tv_total", tv_cnt, 4);
    check_eq("total_nacks", ae_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
